// File: rtl/turret_sprite_fetch_if.sv
// Pixel/ROM/palette signal bundle for the turret sprite fetch stage.
// The master side drives pixel, turret and ROM data; the slave (fetch stage) drives the ROM address and palette outputs.
interface turret_sprite_fetch_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned ADDR_W  = 10
);
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic               pix_valid;
    logic               vsync;
    logic [COORD_W-1:0] turret_x;
    logic [COORD_W-1:0] turret_y;
    logic [1:0]         turret_dir;
    logic [ADDR_W-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic [7:0]         pal_index;
    logic               pal_valid;

    modport master (
        output draw_x, draw_y, pix_valid, vsync, turret_x, turret_y, turret_dir, rom_data,
        input  rom_addr, pal_index, pal_valid
    );

    modport slave (
        input  draw_x, draw_y, pix_valid, vsync, turret_x, turret_y, turret_dir, rom_data,
        output rom_addr, pal_index, pal_valid
    );
endinterface

// File: rtl/turret_sprite_fetch.sv
// Turret sprite hit test, 90-degree rotation and sprite-ROM fetch; three-cycle fixed latency
// from draw coordinates to palette index. Turret position/direction shadowed on vsync fall.
module turret_sprite_fetch #(
    parameter int unsigned SPR_N     = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned COORD_W   = 10,
    parameter logic [7:0]  TRANS_IDX = 8'd0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    turret_sprite_fetch_if.slave   bus
);
    localparam int unsigned LOG_N = $clog2(SPR_N);
    localparam int unsigned D_W   = COORD_W + 1;
    localparam logic [LOG_N-1:0] M = LOG_N'(SPR_N - 1);

    logic [COORD_W-1:0] r_sx;
    logic [COORD_W-1:0] r_sy;
    logic [1:0]         r_sdir;
    logic               r_vsync_q;
    logic               r_hit1;
    logic               r_hit2;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [7:0]         r_pal_index;
    logic               r_pal_valid;

    logic [D_W-1:0]     w_dx;
    logic [D_W-1:0]     w_dy;
    logic               w_in_x;
    logic               w_in_y;
    logic               w_hit0;
    logic [LOG_N-1:0]   w_dxl;
    logic [LOG_N-1:0]   w_dyl;
    logic [LOG_N-1:0]   w_u;
    logic [LOG_N-1:0]   w_v;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_vs_fall;
    logic               w_opaque;

    // Offsets carry an extra sign bit so pixels left/above the sprite never wrap into it
    assign w_dx   = {1'b0, bus.draw_x} - {1'b0, r_sx};
    assign w_dy   = {1'b0, bus.draw_y} - {1'b0, r_sy};
    assign w_in_x = ~w_dx[D_W-1] & (w_dx[D_W-2:LOG_N] == '0);
    assign w_in_y = ~w_dy[D_W-1] & (w_dy[D_W-2:LOG_N] == '0);
    assign w_hit0 = bus.pix_valid & w_in_x & w_in_y;
    assign w_dxl  = w_dx[LOG_N-1:0];
    assign w_dyl  = w_dy[LOG_N-1:0];

    // Rotate sprite-local coordinates into ROM (u,v) space
    always_comb begin
        w_u = w_dxl;
        w_v = w_dyl;
        case (r_sdir)
            2'd1: begin w_u = w_dyl;     w_v = M - w_dxl; end
            2'd2: begin w_u = M - w_dxl; w_v = M - w_dyl; end
            2'd3: begin w_u = M - w_dyl; w_v = w_dxl;     end
            default: ;
        endcase
    end

    assign w_addr    = ADDR_W'({w_v, w_u});
    assign w_vs_fall = r_vsync_q & ~bus.vsync;
    assign w_opaque  = r_hit2 & (bus.rom_data != TRANS_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sx        <= '0;
            r_sy        <= '0;
            r_sdir      <= '0;
            r_vsync_q   <= 1'b0;
            r_hit1      <= 1'b0;
            r_hit2      <= 1'b0;
            r_rom_addr  <= '0;
            r_pal_index <= '0;
            r_pal_valid <= 1'b0;
        end else begin
            r_vsync_q <= bus.vsync;
            if (w_vs_fall) begin
                r_sx   <= bus.turret_x;
                r_sy   <= bus.turret_y;
                r_sdir <= bus.turret_dir;
            end
            r_rom_addr  <= w_hit0 ? w_addr : '0;
            r_hit1      <= w_hit0;
            r_hit2      <= r_hit1;
            r_pal_valid <= w_opaque;
            r_pal_index <= w_opaque ? bus.rom_data : 8'd0;
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.pal_index = r_pal_index;
    assign bus.pal_valid = r_pal_valid;
endmodule

// File: tb/tb_turret_sprite_fetch.sv
// Randomized and directed bench for turret_sprite_fetch against a coordinate-level reference model
// with a registered sprite ROM.
module tb_turret_sprite_fetch;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned ADDR_W  = 10;
    localparam int          SPR     = 32;
    localparam int          NMAX    = 8192;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    turret_sprite_fetch_if #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) bus ();

    turret_sprite_fetch #(.SPR_N(32), .ADDR_W(ADDR_W), .COORD_W(COORD_W), .TRANS_IDX(8'd0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] mem [0:1023];
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    int n_chk = 0;
    int n_pass = 0;

    int tx, ty, td, vs;
    int m_sx, m_sy, m_sdir, m_vprev;
    int cyc, base;
    int e_addr [0:NMAX-1];
    int e_idx  [0:NMAX-1];
    int e_val  [0:NMAX-1];
    int obs_addr, obs_idx, obs_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_sdir = 0; m_vprev = 0;
        base = cyc;
    endtask

    // One pixel per clock: check what matured on this edge, then present the next pixel
    task automatic push(input int x, input int y, input bit pv);
        int xm, ym, dx, dy, u, v, a;
        bit hit;
        @(posedge clk); #1;
        obs_addr = int'(bus.rom_addr);
        obs_idx  = int'(bus.pal_index);
        obs_val  = int'(bus.pal_valid);
        if (cyc - 1 >= base) check("rom_addr", 32'(bus.rom_addr), 32'(e_addr[cyc-1]));
        if (cyc - 3 >= base) begin
            check("pal_index", 32'(bus.pal_index), 32'(e_idx[cyc-3]));
            check("pal_valid", 32'(bus.pal_valid), 32'(e_val[cyc-3]));
        end
        xm = x & 1023;
        ym = y & 1023;
        bus.draw_x     = 10'(xm);
        bus.draw_y     = 10'(ym);
        bus.pix_valid  = pv;
        bus.vsync      = 1'(vs);
        bus.turret_x   = 10'(tx);
        bus.turret_y   = 10'(ty);
        bus.turret_dir = 2'(td);
        dx = xm - m_sx;
        dy = ym - m_sy;
        hit = pv && dx >= 0 && dx < SPR && dy >= 0 && dy < SPR;
        case (m_sdir)
            1: begin u = dy;          v = SPR - 1 - dx; end
            2: begin u = SPR - 1 - dx; v = SPR - 1 - dy; end
            3: begin u = SPR - 1 - dy; v = dx;          end
            default: begin u = dx; v = dy; end
        endcase
        a = v * SPR + u;
        e_addr[cyc] = hit ? a : 0;
        e_val[cyc]  = (hit && mem[hit ? a : 0] != 8'd0) ? 1 : 0;
        e_idx[cyc]  = e_val[cyc] ? int'(mem[a]) : 0;
        if (m_vprev == 1 && vs == 0) begin
            m_sx = tx; m_sy = ty; m_sdir = td;
        end
        m_vprev = vs;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(0, 0, 1'b0);
    endtask

    task automatic vsync_pulse();
        vs = 1; push(0, 0, 1'b0);
        vs = 0; push(0, 0, 1'b0);
        vs = 1; push(0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        tx = 0; ty = 0; td = 0; vs = 1;
        bus.draw_x = '0; bus.draw_y = '0; bus.pix_valid = 1'b0; bus.vsync = 1'b1;
        bus.turret_x = '0; bus.turret_y = '0; bus.turret_dir = '0;
        cyc = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_pal_index", 32'(bus.pal_index), 32'd0);
        check("rst_pal_valid", 32'(bus.pal_valid), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        model_reset();

        // Top-left / bottom-right corners with dir 0
        mem[0] = 8'h05; mem[1023] = 8'h7e; mem[5] = 8'h00; mem[1] = 8'h11;
        tx = 100; ty = 50; td = 0;
        vsync_pulse();
        push(100, 50, 1'b1);
        push(131, 81, 1'b1);
        check("tl_addr", 32'(obs_addr), 32'd0);
        push(0, 0, 1'b0);
        check("br_addr", 32'(obs_addr), 32'd1023);
        push(0, 0, 1'b0);
        check("tl_pal_index", 32'(obs_idx), 32'h05);
        check("tl_pal_valid", 32'(obs_val), 32'd1);

        // Just outside the box and a transparent texel inside it
        push(132, 50, 1'b1);
        push(99, 50, 1'b1);
        push(105, 50, 1'b1);
        idle(1);
        check("right_miss_valid", 32'(obs_val), 32'd0);
        idle(1);
        check("left_miss_valid", 32'(obs_val), 32'd0);
        idle(1);
        check("transp_valid", 32'(obs_val), 32'd0);
        check("transp_index", 32'(obs_idx), 32'd0);

        // Rotations
        td = 1; vsync_pulse(); push(100, 50, 1'b1); idle(1);
        check("dir1_addr", 32'(obs_addr), 32'd992);
        push(101, 50, 1'b1); idle(1);
        check("dir1_x1_addr", 32'(obs_addr), 32'd960);
        td = 2; vsync_pulse(); push(100, 50, 1'b1); idle(1);
        check("dir2_addr", 32'(obs_addr), 32'd1023);
        td = 3; vsync_pulse(); push(100, 50, 1'b1); idle(1);
        check("dir3_addr", 32'(obs_addr), 32'd31);

        // Mid-frame move without vsync must not take effect
        td = 0; vsync_pulse();
        tx = 200;
        push(101, 50, 1'b1); idle(1);
        check("nomove_old_hit", 32'(obs_addr), 32'd1);
        push(201, 50, 1'b1); idle(1);
        check("nomove_new_miss", 32'(obs_addr), 32'd0);
        vsync_pulse();
        push(201, 50, 1'b1); idle(1);
        check("moved_new_hit", 32'(obs_addr), 32'd1);
        push(101, 50, 1'b1); idle(1);
        check("moved_old_miss", 32'(obs_addr), 32'd0);

        // Partly off-screen sprite
        tx = 620; ty = 470; vsync_pulse();
        push(639, 479, 1'b1); idle(1);
        check("edge_addr", 32'(obs_addr), 32'd307);
        push(0, 0, 1'b1); idle(1);
        check("nowrap_addr", 32'(obs_addr), 32'd0);

        // Asynchronous reset in the middle of a stream of hits
        push(625, 475, 1'b1);
        push(626, 476, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("async_pal_index", 32'(bus.pal_index), 32'd0);
        check("async_pal_valid", 32'(bus.pal_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        vs = 1;
        push(3, 2, 1'b1); idle(1);
        check("post_rst_origin", 32'(obs_addr), 32'd67);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int px, py;
            if ($urandom_range(0, 199) == 0) begin
                tx = $urandom_range(0, 639);
                ty = $urandom_range(0, 479);
                td = $urandom_range(0, 3);
            end
            vs = ($urandom_range(0, 31) == 0) ? 0 : 1;
            px = tx + int'($urandom_range(0, 40)) - 4;
            py = ty + int'($urandom_range(0, 40)) - 4;
            push(px, py, $urandom_range(0, 7) != 0);
        end
        vs = 1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
